// File: rtl/cpu_debug_scan_pkg.sv
// Shared types and constants for the CPU debug virtual-JTAG scan master.
package cpu_debug_scan_pkg;

    localparam int unsigned DrWidthDefault = 38;
    localparam int unsigned IrWidthDefault = 2;
    localparam int unsigned TckDivDefault  = 2;

    // Virtual IR instruction encodings understood by the debug-module tck side.
    localparam logic [1:0] IrMonitor = 2'b00;
    localparam logic [1:0] IrRead    = 2'b01;
    localparam logic [1:0] IrWrite   = 2'b10;
    localparam logic [1:0] IrStatus  = 2'b11;

    // One state per virtual-JTAG phase; every busy state lasts one tck period except Shift.
    typedef enum logic [2:0] {
        StIdle,
        StUir,
        StRti1,
        StCdr,
        StShift,
        StUdr,
        StRti2,
        StResp
    } scan_state_e;

endpackage

// File: rtl/cpu_debug_scan_master_if.sv
// Command/response and virtual-JTAG signal bundle for cpu_debug_scan_master.
// master: the scan initiator. slave: the command source plus the debug-module target.
interface cpu_debug_scan_master_if
    import cpu_debug_scan_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DrWidthDefault,
    parameter int unsigned IR_WIDTH = IrWidthDefault
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir;
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic [IR_WIDTH-1:0] vji_ir_out;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;

    modport master (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir,
        output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir,
        input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

endinterface

// File: rtl/cpu_debug_scan_tck_gen.sv
// Test-clock generator: divides clk by 2*TCK_DIV while run is high and flags
// the clk edge on which tck rises or falls. tck parks low whenever run is low.
module cpu_debug_scan_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam logic [7:0] HalfLast = 8'(TCK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       tck_q, tck_d;
    logic       half_done;

    // Half-period count; tck_rise/tck_fall mark the edge that toggles tck.
    always_comb begin
        half_done = run && (cnt_q == HalfLast);
        tck_rise  = half_done && !tck_q;
        tck_fall  = half_done && tck_q;
        cnt_d     = '0;
        tck_d     = 1'b0;
        if (run) begin
            cnt_d = half_done ? 8'd0 : cnt_q + 8'd1;
            tck_d = half_done ? !tck_q : tck_q;
        end
    end

    // Divider state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck = tck_q;

endmodule

// File: rtl/cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator: turns one IR+DR command into the
// UIR/RTI/CDR/SHIFT/UDR/RTI strobe sequence and returns the captured DR.
// Optional feature macro: CPU_DEBUG_SCAN_IR_READBACK_EN (return vji_ir_out on rsp_ir).
module cpu_debug_scan_master
    import cpu_debug_scan_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DrWidthDefault,
    parameter int unsigned IR_WIDTH = IrWidthDefault,
    parameter int unsigned TCK_DIV  = TckDivDefault
) (
    input logic                      clk,
    input logic                      reset,
    cpu_debug_scan_master_if.master  bus
);

    localparam int unsigned           CntWidth = $clog2(DR_WIDTH + 1);
    localparam logic [CntWidth-1:0]   LastBit  = CntWidth'(DR_WIDTH - 1);

    scan_state_e         state_q, state_d;
    logic [DR_WIDTH-1:0] dr_shift_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic [CntWidth-1:0] bit_cnt_q;
    logic                last_bit_q;
    logic                tdi_q;
    logic                cmd_ready_q, cmd_ready_d;
    logic                accept;
    logic                run;
    logic                tck_rise;
    logic                tck_fall;

    assign run    = (state_q != StIdle) && (state_q != StResp);
    assign accept = bus.cmd_valid && cmd_ready_q;

    cpu_debug_scan_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .tck      (bus.vji_tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Next state: busy phases advance on tck falls so strobes span whole periods.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StUir;
            StUir:   if (tck_fall) state_d = StRti1;
            StRti1:  if (tck_fall) state_d = StCdr;
            StCdr:   if (tck_fall) state_d = StShift;
            StShift: if (tck_fall && last_bit_q) state_d = StUdr;
            StUdr:   if (tck_fall) state_d = StRti2;
            StRti2:  if (tck_fall) state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Ready is registered, so it reappears one cycle after the response handshake.
        cmd_ready_d = (state_q == StIdle) && !accept;
    end

    // Command latch, DR shift on tck rises and tdi update on tck falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dr_shift_q <= '0;
            ir_q       <= '0;
            bit_cnt_q  <= '0;
            last_bit_q <= 1'b0;
            tdi_q      <= 1'b0;
        end else begin
            if (accept) begin
                dr_shift_q <= bus.cmd_dr;
                ir_q       <= bus.cmd_ir;
                bit_cnt_q  <= '0;
                last_bit_q <= 1'b0;
            end else if ((state_q == StShift) && tck_rise) begin
                dr_shift_q <= {bus.vji_tdo, dr_shift_q[DR_WIDTH-1:1]};
                if (bit_cnt_q == LastBit) begin
                    last_bit_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
            if (tck_fall) begin
                tdi_q <= (state_d == StShift) ? dr_shift_q[0] : 1'b0;
            end
        end
    end

`ifdef CPU_DEBUG_SCAN_IR_READBACK_EN
    logic [IR_WIDTH-1:0] rsp_ir_q;

    // Capture the target IR status on the UDR tck rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_ir_q <= '0;
        end else if ((state_q == StUdr) && tck_rise) begin
            rsp_ir_q <= bus.vji_ir_out;
        end
    end

    assign bus.rsp_ir = rsp_ir_q;
`else
    logic [IR_WIDTH-1:0] unused_ir_out;
    assign unused_ir_out = bus.vji_ir_out;
    assign bus.rsp_ir    = '0;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_dr    = dr_shift_q;
    assign bus.vji_tdi   = tdi_q;
    assign bus.vji_ir_in = ir_q;
    assign bus.vji_uir   = (state_q == StUir);
    assign bus.vji_cdr   = (state_q == StCdr);
    assign bus.vji_sdr   = (state_q == StShift);
    assign bus.vji_udr   = (state_q == StUdr);
    assign bus.vji_rti   = (state_q == StRti1) || (state_q == StRti2);

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Directed bench for cpu_debug_scan_master: a TCK_DIV=2 and a TCK_DIV=1 instance,
// each driving a 38-bit target shift register loaded at CDR and latched at UDR.
module tb_cpu_debug_scan_master;
    import cpu_debug_scan_pkg::*;

    localparam int unsigned DrW = 38;
    localparam int unsigned IrW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_debug_scan_master_if #(.DR_WIDTH(DrW), .IR_WIDTH(IrW)) bus0 ();
    cpu_debug_scan_master_if #(.DR_WIDTH(DrW), .IR_WIDTH(IrW)) bus1 ();

    cpu_debug_scan_master #(.DR_WIDTH(DrW), .IR_WIDTH(IrW), .TCK_DIV(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    cpu_debug_scan_master #(.DR_WIDTH(DrW), .IR_WIDTH(IrW), .TCK_DIV(1)) u_dut_div1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Target models: capture preload at CDR, shift tdi in at the top, latch at UDR.
    logic [DrW-1:0] pre0 = '0, tgt0 = '0, upd0 = '0;
    logic [DrW-1:0] pre1 = '0, tgt1 = '0, upd1 = '0;

    assign bus0.vji_tdo    = tgt0[0];
    assign bus1.vji_tdo    = tgt1[0];
    assign bus0.vji_ir_out = 2'b10;
    assign bus1.vji_ir_out = 2'b10;

    always @(posedge bus0.vji_tck) begin
        if (bus0.vji_cdr) tgt0 <= pre0;
        else if (bus0.vji_sdr) tgt0 <= {bus0.vji_tdi, tgt0[DrW-1:1]};
        if (bus0.vji_udr) upd0 <= tgt0;
    end

    always @(posedge bus1.vji_tck) begin
        if (bus1.vji_cdr) tgt1 <= pre1;
        else if (bus1.vji_sdr) tgt1 <= {bus1.vji_tdi, tgt1[DrW-1:1]};
        if (bus1.vji_udr) upd1 <= tgt1;
    end

    // Handshake counters for the held-valid case.
    int acc0 = 0;
    int hs0  = 0;
    always @(posedge clk) begin
        if (bus0.cmd_valid && bus0.cmd_ready) acc0 <= acc0 + 1;
        if (bus0.rsp_valid && bus0.rsp_ready) hs0 <= hs0 + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command on bus0 and sample every cycle until rsp_valid (bounded).
    task automatic scan0(input logic [IrW-1:0] ir, input logic [DrW-1:0] dr, output int lat,
                         output int w_uir, output int w_cdr, output int w_sdr, output int w_udr,
                         output logic [IrW-1:0] ir_seen);
        lat = -1; w_uir = 0; w_cdr = 0; w_sdr = 0; w_udr = 0; ir_seen = '0;
        bus0.cmd_ir = ir;
        bus0.cmd_dr = dr;
        bus0.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus0.cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus0.cmd_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (bus0.rsp_valid) begin
                lat = c;
                break;
            end
            if (bus0.vji_uir) begin
                w_uir++;
                ir_seen = bus0.vji_ir_in;
            end
            if (bus0.vji_cdr) w_cdr++;
            if (bus0.vji_sdr) w_sdr++;
            if (bus0.vji_udr) w_udr++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int             lat, w_uir, w_cdr, w_sdr, w_udr, lat1, acc_base, hs_base;
        logic [IrW-1:0] ir_seen;
        logic           stable, seen;

        bus0.cmd_valid = 1'b0; bus0.cmd_ir = '0; bus0.cmd_dr = '0; bus0.rsp_ready = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_ir = '0; bus1.cmd_dr = '0; bus1.rsp_ready = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus0.cmd_ready, 1'b0);
        check("rst_rsp_valid", bus0.rsp_valid, 1'b0);
        check("rst_tck", bus0.vji_tck, 1'b0);
        check("rst_strobes", {bus0.vji_uir, bus0.vji_cdr, bus0.vji_sdr, bus0.vji_udr,
                              bus0.vji_rti}, 5'b0);
        check("rst_rsp_dr", bus0.rsp_dr, 38'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", bus0.cmd_ready, 1'b1);

        // Case 1/2: data exchange, latency, strobe widths.
        pre0 = 38'h2A_5555_AAAA;
        scan0(2'b01, 38'h15_0F0F_F0F0, lat, w_uir, w_cdr, w_sdr, w_udr, ir_seen);
        check("c1_latency", lat, 172);
        check("c1_uir_width", w_uir, 4);
        check("c1_cdr_width", w_cdr, 4);
        check("c1_sdr_width", w_sdr, 152);
        check("c1_udr_width", w_udr, 4);
        check("c1_ir_in", ir_seen, 2'b01);
        check("c1_rsp_dr", bus0.rsp_dr, 38'h2A_5555_AAAA);
        check("c1_target_upd", upd0, 38'h15_0F0F_F0F0);
        check("c1_tck_idle", bus0.vji_tck, 1'b0);
`ifdef CPU_DEBUG_SCAN_IR_READBACK_EN
        check("c6_rsp_ir", bus0.rsp_ir, 2'b10);
`else
        check("c6_rsp_ir", bus0.rsp_ir, 2'b00);
`endif

        // Case 3: response held under backpressure, then taken.
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!bus0.rsp_valid || bus0.rsp_dr !== 38'h2A_5555_AAAA || bus0.cmd_ready)
                stable = 1'b0;
        end
        check("c3_hold_stable", stable, 1'b1);
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.rsp_ready = 1'b0;
        check("c3_valid_drop", bus0.rsp_valid, 1'b0);
        check("c3_ready_late", bus0.cmd_ready, 1'b0);
        @(posedge clk); #1;
        check("c3_ready_back", bus0.cmd_ready, 1'b1);

        // Case 4: reset during SHIFT bit 10.
        pre0 = 38'h12_3456_789A;
        bus0.cmd_ir = 2'b10;
        bus0.cmd_dr = 38'h3F_0000_FFFF;
        bus0.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus0.cmd_valid = 1'b0;
        repeat (52) @(posedge clk);
        #1;
        check("c4_in_shift", bus0.vji_sdr, 1'b1);
        reset = 1'b1;
        #1;
        check("c4_rst_rsp_valid", bus0.rsp_valid, 1'b0);
        check("c4_rst_cmd_ready", bus0.cmd_ready, 1'b0);
        check("c4_rst_tck_tdi", {bus0.vji_tck, bus0.vji_tdi}, 2'b00);
        check("c4_rst_strobes", {bus0.vji_uir, bus0.vji_cdr, bus0.vji_sdr, bus0.vji_udr,
                                 bus0.vji_rti}, 5'b0);
        check("c4_rst_ir_in", bus0.vji_ir_in, 2'b00);
        check("c4_rst_rsp_dr", bus0.rsp_dr, 38'h0);
        check("c4_rst_rsp_ir", bus0.rsp_ir, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (bus0.rsp_valid) seen = 1'b1;
        end
        check("c4_no_stale_rsp", seen, 1'b0);

        // Clean rescan with rsp_ready already high: single-cycle response pulse.
        pre0 = 38'h3C_C33C_C33C;
        bus0.rsp_ready = 1'b1;
        scan0(2'b11, 38'h0, lat, w_uir, w_cdr, w_sdr, w_udr, ir_seen);
        check("c4_latency", lat, 172);
        check("c4_rsp_dr", bus0.rsp_dr, 38'h3C_C33C_C33C);
        check("c4_target_upd", upd0, 38'h0);
        @(posedge clk); #1;
        check("c4_valid_pulse", bus0.rsp_valid, 1'b0);

        // Case 5: cmd_valid held high across three scans.
        acc_base = acc0;
        hs_base  = hs0;
        bus0.cmd_dr = 38'h01_2345_6789;
        bus0.cmd_valid = 1'b1;
        for (int i = 0; i < 1000 && (hs0 - hs_base) < 3; i++) begin
            @(posedge clk); #1;
        end
        bus0.cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("c5_responses", hs0 - hs_base, 3);
        check("c5_accepts", acc0 - acc_base, 3);
        bus0.rsp_ready = 1'b0;

        // Case 5: TCK_DIV=1 instance repeats case 1.
        pre1 = 38'h2A_5555_AAAA;
        bus1.cmd_ir = 2'b01;
        bus1.cmd_dr = 38'h15_0F0F_F0F0;
        bus1.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus1.cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus1.cmd_valid = 1'b0;
        lat1 = -1;
        for (int c = 0; c < 200; c++) begin
            if (bus1.rsp_valid) begin
                lat1 = c;
                break;
            end
            @(posedge clk); #1;
        end
        check("div1_latency", lat1, 86);
        check("div1_rsp_dr", bus1.rsp_dr, 38'h2A_5555_AAAA);
        check("div1_target_upd", upd1, 38'h15_0F0F_F0F0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
